// File: rtl/dual_threshold.sv
// Dual-threshold classifier: scans one NMS frame a pixel per clock into strong/weak
// edge frames, then pulses dual_val and publishes per-frame strong/weak counts.
//
//   state | meaning
//   IDLE  | waiting for nms_val; latches thresholds on accept
//   SCAN  | classifying one pixel per clock in raster order
//   DONE  | one-cycle completion slot while dual_val is high
module dual_threshold #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int PIX_WIDTH    = 24,
  parameter int CNT_W        = $clog2(FRAME_WIDTH*FRAME_HEIGHT+1),
  localparam int GW          = PIX_WIDTH/3
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          nms_val,
  input  logic [FRAME_HEIGHT-1:0][FRAME_WIDTH-1:0][GW-1:0] nms_frame,
  input  logic [GW-1:0]                                 high_thr,
  input  logic [GW-1:0]                                 low_thr,
  output logic                                          dual_val,
  output logic [FRAME_HEIGHT-1:0][FRAME_WIDTH-1:0][GW-1:0] str_edge,
  output logic [FRAME_HEIGHT-1:0][FRAME_WIDTH-1:0][GW-1:0] weak_edge,
  output logic [CNT_W-1:0]                              str_cnt,
  output logic [CNT_W-1:0]                              weak_cnt
);

  localparam int XW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
  localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH-1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT-1);
  localparam logic [GW-1:0] STR_VAL  = GW'(255);
  localparam logic [GW-1:0] WEAK_VAL = GW'(128);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, next_state;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [GW-1:0]    hi_q, lo_q;
  logic [CNT_W-1:0] str_run, weak_run;
  logic [GW-1:0]    pix;
  logic             is_str, is_weak, last_pix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE: next_state = nms_val ? SCAN : IDLE;
      SCAN: next_state = last_pix ? DONE : SCAN;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // lo_q never exceeds hi_q, so a pixel failing the strong test only needs the low test.
  always_comb begin
    pix      = nms_frame[y][x];
    is_str   = (pix >= hi_q);
    is_weak  = !is_str && (pix >= lo_q);
    last_pix = (x == X_LAST) && (y == Y_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      str_run   <= '0;
      weak_run  <= '0;
      dual_val  <= 1'b0;
      str_cnt   <= '0;
      weak_cnt  <= '0;
      str_edge  <= '0;
      weak_edge <= '0;
    end else begin
      dual_val <= 1'b0;
      case (state)
        IDLE: begin
          if (nms_val) begin
            hi_q     <= high_thr;
            lo_q     <= (low_thr > high_thr) ? high_thr : low_thr;
            x        <= '0;
            y        <= '0;
            str_run  <= '0;
            weak_run <= '0;
          end
        end
        SCAN: begin
          str_edge[y][x]  <= is_str  ? STR_VAL  : '0;
          weak_edge[y][x] <= is_weak ? WEAK_VAL : '0;
          str_run  <= str_run  + CNT_W'(is_str);
          weak_run <= weak_run + CNT_W'(is_weak);
          if (x == X_LAST) begin
            x <= '0;
            y <= y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
          if (last_pix) begin
            dual_val <= 1'b1;
            str_cnt  <= str_run  + CNT_W'(is_str);
            weak_cnt <= weak_run + CNT_W'(is_weak);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_threshold.sv
// Scoreboarded bench for dual_threshold: the driver pushes model results per accepted
// frame, the monitor pops and checks them whenever dual_val is seen.
module tb_dual_threshold;
  localparam int FW = 4;
  localparam int FH = 3;
  localparam int N  = FW*FH;
  localparam int CW = $clog2(FW*FH+1);

  typedef logic [FH-1:0][FW-1:0][7:0] frame_t;
  typedef struct packed {
    frame_t         s;
    frame_t         w;
    logic [CW-1:0]  sc;
    logic [CW-1:0]  wc;
    logic [31:0]    due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          nms_val = 1'b0;
  frame_t        nms_frame = '0;
  logic [7:0]    high_thr = '0;
  logic [7:0]    low_thr = '0;
  logic          dual_val;
  frame_t        str_edge, weak_edge;
  logic [CW-1:0] str_cnt, weak_cnt;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t sb[$];

  dual_threshold #(.FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .PIX_WIDTH(24)) dut (
    .clk(clk), .rst_n(rst_n), .nms_val(nms_val), .nms_frame(nms_frame),
    .high_thr(high_thr), .low_thr(low_thr), .dual_val(dual_val),
    .str_edge(str_edge), .weak_edge(weak_edge), .str_cnt(str_cnt), .weak_cnt(weak_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: each pixel classified against the effective band [min(lo,hi), hi).
  function automatic exp_t model(input frame_t f, input int hi, input int lo);
    exp_t e;
    int   nstr, nweak, lo_eff;
    e = '0;
    nstr = 0;
    nweak = 0;
    lo_eff = (lo > hi) ? hi : lo;
    for (int yy = 0; yy < FH; yy++)
      for (int xx = 0; xx < FW; xx++) begin
        int p;
        p = int'(f[yy][xx]);
        if (p >= hi) begin
          e.s[yy][xx] = 8'd255;
          nstr++;
        end else if (p >= lo_eff) begin
          e.w[yy][xx] = 8'd128;
          nweak++;
        end
      end
    e.sc = CW'(nstr);
    e.wc = CW'(nweak);
    return e;
  endfunction

  task automatic edge_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int yy = 0; yy < FH; yy++)
      for (int xx = 0; xx < FW; xx++)
        f[yy][xx] = 8'($urandom_range(0, 255));
    return f;
  endfunction

  function automatic frame_t const_frame(input logic [7:0] v);
    frame_t f;
    for (int yy = 0; yy < FH; yy++)
      for (int xx = 0; xx < FW; xx++)
        f[yy][xx] = v;
    return f;
  endfunction

  // Called just after a clock edge with the DUT in IDLE; returns just after the
  // edge that brings it back to IDLE (accept edge + N + 1).
  task automatic run_frame(input frame_t f, input logic [7:0] hi, input logic [7:0] lo,
                           input bit hold, input bit perturb);
    exp_t e;
    nms_frame = f;
    high_thr  = hi;
    low_thr   = lo;
    nms_val   = 1'b1;
    e = model(f, int'(hi), int'(lo));
    e.due = 32'(cyc + 1 + N);
    sb.push_back(e);
    edge_wait(1);
    if (!hold) nms_val = 1'b0;
    for (int i = 0; i < N + 1; i++) begin
      if (perturb) begin
        high_thr = 8'($urandom_range(0, 255));
        low_thr  = 8'($urandom_range(0, 255));
        nms_val  = 1'($urandom_range(0, 1));
      end
      edge_wait(1);
    end
    if (!hold) nms_val = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dual_val"}, int'(dual_val), 0);
    check({tag, "_str_cnt"}, int'(str_cnt), 0);
    check({tag, "_weak_cnt"}, int'(weak_cnt), 0);
    for (int yy = 0; yy < FH; yy++)
      for (int xx = 0; xx < FW; xx++) begin
        check($sformatf("%s_str_edge[%0d][%0d]", tag, yy, xx), int'(str_edge[yy][xx]), 0);
        check($sformatf("%s_weak_edge[%0d][%0d]", tag, yy, xx), int'(weak_edge[yy][xx]), 0);
      end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && cyc > int'(sb[0].due)) begin
        void'(sb.pop_front());
        check("dual_val_missing", 0, 1);
      end
      if (dual_val) begin
        if (sb.size() == 0) begin
          check("dual_val_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("dual_val_edge", cyc, int'(e.due));
          check("str_cnt", int'(str_cnt), int'(e.sc));
          check("weak_cnt", int'(weak_cnt), int'(e.wc));
          for (int yy = 0; yy < FH; yy++)
            for (int xx = 0; xx < FW; xx++) begin
              check($sformatf("str_edge[%0d][%0d]", yy, xx), int'(str_edge[yy][xx]), int'(e.s[yy][xx]));
              check($sformatf("weak_edge[%0d][%0d]", yy, xx), int'(weak_edge[yy][xx]), int'(e.w[yy][xx]));
            end
        end
      end
    end
  end

  initial begin
    frame_t f;
    logic [7:0] vals [12];
    int budget;
    vals = '{8'd0, 8'd49, 8'd50, 8'd99, 8'd100, 8'd255, 8'd1, 8'd101, 8'd75, 8'd200, 8'd30, 8'd128};

    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    edge_wait(2);

    // Band edges: exactly-at-threshold pixels fall into the upper class.
    for (int i = 0; i < N; i++) f[i / FW][i % FW] = vals[i];
    run_frame(f, 8'd100, 8'd50, 1'b0, 1'b0);
    edge_wait(1);

    // Inverted thresholds collapse the weak band.
    run_frame(const_frame(8'd150), 8'd100, 8'd200, 1'b0, 1'b0);
    run_frame(const_frame(8'd150), 8'd200, 8'd100, 1'b0, 1'b0);

    // Threshold/nms_val churn during the scan must not matter.
    run_frame(rand_frame(), 8'd140, 8'd60, 1'b0, 1'b1);

    // Mid-scan reset aborts the frame with no pulse.
    nms_frame = rand_frame();
    high_thr  = 8'd90;
    low_thr   = 8'd20;
    nms_val   = 1'b1;
    edge_wait(1);
    nms_val = 1'b0;
    edge_wait(6);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    edge_wait(1);
    run_frame(rand_frame(), 8'd90, 8'd20, 1'b0, 1'b0);

    // Back-to-back frames with nms_val held high.
    for (int k = 0; k < 3; k++)
      run_frame(rand_frame(), 8'($urandom_range(64, 200)), 8'($urandom_range(0, 128)), 1'b1, 1'b0);
    nms_val = 1'b0;
    edge_wait(2);

    run_frame(const_frame(8'd0), 8'd0, 8'd0, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++)
      run_frame(rand_frame(), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'b0, 1'($urandom_range(0, 1)));

    budget = 0;
    while (sb.size() > 0 && budget < 100) begin
      edge_wait(1);
      budget++;
    end
    if (sb.size() > 0) check("scoreboard_drain", sb.size(), 0);
    edge_wait(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dual_threshold.md
# dual_threshold

Dual-threshold classification stage of the Canny edge pipeline. Sits between non-maximum suppression and `hyst_threshold`. It scans one NMS-thinned frame, one pixel per clock, and builds two frames: a strong-edge frame (255 or 0) and a weak-edge frame (128 or 0). It then pulses `dual_val` so the hysteresis stage can start, and publishes per-frame strong and weak pixel counts for debug and threshold tuning.

## Interface
- `FRAME_WIDTH`, 640, frame width in pixels
- `FRAME_HEIGHT`, 480, frame height in pixels
- `PIX_WIDTH`, 24, RGB pixel width; the grayscale pixel width is `PIX_WIDTH/3` (8)
- `CNT_W`, `$clog2(FRAME_WIDTH*FRAME_HEIGHT+1)`, width of the statistics counters
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `nms_val`  in  1  NMS frame valid; starts a scan when sampled high in IDLE
- `nms_frame`  in  `[PIX_WIDTH/3-1:0]` x `[FRAME_HEIGHT-1:0][FRAME_WIDTH-1:0]`  NMS magnitude frame; held stable by upstream for the whole scan
- `high_thr`  in  `PIX_WIDTH/3`  high threshold
- `low_thr`  in  `PIX_WIDTH/3`  low threshold
- `dual_val`  out  1  one-cycle pulse, asserted when both output frames are complete
- `str_edge`  out  `[PIX_WIDTH/3-1:0]` x `[FRAME_HEIGHT-1:0][FRAME_WIDTH-1:0]`  strong-edge frame
- `weak_edge`  out  `[PIX_WIDTH/3-1:0]` x `[FRAME_HEIGHT-1:0][FRAME_WIDTH-1:0]`  weak-edge frame
- `str_cnt`  out  `CNT_W`  number of strong pixels in the last completed frame
- `weak_cnt`  out  `CNT_W`  number of weak pixels in the last completed frame

## Operation
- **State machine:** IDLE, SCAN, DONE. Any other encoding goes to IDLE.
- **IDLE:**
  - Transitions to SCAN when `nms_val` is high.
  - On that same edge: latch `high_thr` into `hi_q`; latch `low_thr` into `lo_q`; clear scan position x and y to 0; clear the running counters.
  - If `low_thr > high_thr`, set `lo_q = high_thr`. This leaves an empty weak band.
- **SCAN:** one pixel per clock, raster order. x runs 0..`FRAME_WIDTH-1`, then wraps to 0 and increments y. For pixel p = `nms_frame[y][x]`:
  - p >= `hi_q`: `str_edge[y][x]` <= 255, `weak_edge[y][x]` <= 0, strong running count +1.
  - `lo_q` <= p < `hi_q`: `str_edge[y][x]` <= 0, `weak_edge[y][x]` <= 128, weak running count +1.
  - p < `lo_q`: both outputs <= 0.
  - Comparisons are unsigned, 8-bit.
  - A threshold of 0 makes every pixel at least that class.
  - `hi_q = 0` makes every pixel strong.
- **Leaving SCAN:** after writing pixel (`FRAME_HEIGHT-1`, `FRAME_WIDTH-1`), go to DONE. On that same edge:
  - `dual_val` <= 1.
  - `str_cnt` and `weak_cnt` <= final running counts, including the last pixel.
- **DONE:** unconditionally go to IDLE on the next edge; `dual_val` <= 0.
- **Ignored inputs:** `nms_val` is ignored in SCAN and DONE. Threshold inputs are used only at the moment they are latched; changing them mid-scan has no effect.
- **Output frame stability:** output frames are written only in SCAN and are stable in IDLE and DONE. The downstream stage reads them after `dual_val` and before the next accepted `nms_val`.
- **Reset (asynchronous, active-low), including mid-scan:**
  - State returns to IDLE.
  - x, y and all counters clear.
  - `dual_val` = 0, `str_cnt` = 0, `weak_cnt` = 0.
  - Every `str_edge` and `weak_edge` element = 0.
  - No `dual_val` pulse is produced for an aborted frame.

## Timing
- Accepting edge E: `nms_val` is high while in IDLE.
- Pixel (y, x) is written on edge E+1+y·`FRAME_WIDTH`+x.
- The last pixel is written on edge E+N, where N = `FRAME_WIDTH`·`FRAME_HEIGHT`.
- `dual_val` is high for exactly one cycle, from edge E+N to edge E+N+1. `str_cnt` and `weak_cnt` become valid at edge E+N.
- The earliest next accept is edge E+N+2. Frame period is N+2 cycles minimum.
- `nms_val` held high continuously gives back-to-back frames every N+2 cycles.
- The downstream stage must be idle when `dual_val` pulses; the pulse is not re-issued.

## Test plan
Parameters: `FRAME_WIDTH`=4, `FRAME_HEIGHT`=3 (N=12).
1. `high_thr`=100, `low_thr`=50, frame values {0, 49, 50, 99, 100, 255, ...} → strong pixels read 255 exactly where value >= 100, weak pixels read 128 where 50..99, all other outputs 0; `str_cnt`/`weak_cnt` match; `dual_val` is high exactly 12 cycles after the accept edge, for one cycle.
2. `low_thr`=200, `high_thr`=100 (inverted), all pixels 150 → `weak_cnt`=0, `str_cnt`=12, no 128 values in `weak_edge`.
3. Change thresholds and toggle `nms_val` during SCAN → output unchanged versus a run with stable inputs; single `dual_val` pulse.
4. Assert `rst_n`=0 at cycle 6 of SCAN → all outputs 0 immediately; no `dual_val`; next `nms_val` produces a correct full frame.
5. `nms_val` held high for 3 frames with distinct data → `dual_val` pulses at E+12, E+26, E+40; counts update at each pulse.
6. `high_thr`=0, `low_thr`=0, all-zero frame → `str_cnt`=12, `weak_cnt`=0, all `str_edge`=255.
